// File: rtl/ula_vram_port.sv
// ula_vram_port: responder side of the ULA video RAM fetch interface.
// Owns the 8 KB screen RAM (single port, synchronous read). Video reads have
// absolute priority; Z80 screen writes are queued in a small FIFO and drained
// only in cycles the video leaves free. A clear sweep fills the bitmap with 0
// and the attribute area with a latched value.
//
// Ports:
//   clk_pix, nreset             pixel clock, async active-low reset
//   vid_req, vid_addr, vid_data video read strobe/address, data valid 2 cycles later
//   cpu_wr_req, cpu_addr,       Z80 write request (0x4000..0x5AFF kept,
//   cpu_wdata, cpu_wr_ready     everything else consumed and dropped)
//   fifo_level                  write FIFO occupancy
//   clr_start, clr_attr         clear-screen request and attribute fill value
//   clr_busy                    clear sweep in progress
module ula_vram_port #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SCREEN_BYTES = 6912,
  parameter logic [12:0] ATTR_BASE    = 13'h1800
) (
  input  logic                          clk_pix,
  input  logic                          nreset,
  input  logic                          vid_req,
  input  logic [12:0]                   vid_addr,
  output logic [7:0]                    vid_data,
  input  logic                          cpu_wr_req,
  input  logic [15:0]                   cpu_addr,
  input  logic [7:0]                    cpu_wdata,
  output logic                          cpu_wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          clr_start,
  input  logic [7:0]                    clr_attr,
  output logic                          clr_busy
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW    = PtrW + 1;
  localparam logic [12:0] ClrLast = 13'(SCREEN_BYTES - 1);

  typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

  // Screen RAM and its read register (no reset: contents survive reset)
  logic [7:0]  mem [8192];
  logic [7:0]  ram_rdata_q;
  logic        ram_we;
  logic [12:0] ram_waddr;
  logic [7:0]  ram_wdata;

  // Write FIFO entries are {vram_addr[12:0], data[7:0]}
  logic [20:0]     fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            full, in_range, push, pop;
  logic [20:0]     head;

  clr_state_e  state_q, state_d;
  logic [12:0] clr_ptr_q, clr_ptr_d;
  logic [7:0]  clr_attr_q, clr_attr_d;
  logic        clr_we;

  logic        rd_pend_q;
  logic [7:0]  vid_data_q;

  // ---------------- FIFO ----------------
  assign full         = (level_q == LvlW'(FIFO_DEPTH));
  assign cpu_wr_ready = !full;
  assign in_range     = (cpu_addr >= 16'h4000) && (cpu_addr <= 16'h5AFF);
  assign push         = cpu_wr_req && !full && in_range;
  assign pop          = !vid_req && (state_q == StIdle) && (level_q != '0);
  assign head         = fifo_mem[rd_ptr_q];
  assign fifo_level   = level_q;

  // cpu_addr - 0x4000 truncated to 13 bits is simply cpu_addr[12:0]
  always_ff @(posedge clk_pix) begin
    if (push) fifo_mem[wr_ptr_q] <= {cpu_addr[12:0], cpu_wdata};
  end

  always_ff @(posedge clk_pix or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      level_q <= level_q + LvlW'(1);
      else if (pop && !push) level_q <= level_q - LvlW'(1);
    end
  end

  // ---------------- Clear FSM ----------------
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_attr_d = clr_attr_q;
    clr_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d    = StClear;
          clr_attr_d = clr_attr;
          clr_ptr_d  = '0;
        end
      end
      StClear: begin
        if (!vid_req) begin
          clr_we = 1'b1;
          if (clr_ptr_q == ClrLast) state_d = StIdle;
          else                      clr_ptr_d = clr_ptr_q + 13'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_pix or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      clr_ptr_q  <= '0;
      clr_attr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_attr_q <= clr_attr_d;
    end
  end

  // Decoded from state so an async reset drops it immediately
  assign clr_busy = (state_q == StClear);

  // ---------------- RAM port ----------------
  // clr_we and pop are exclusive: pop requires StIdle, clr_we requires StClear.
  always_comb begin
    ram_we    = clr_we || pop;
    ram_waddr = head[20:8];
    ram_wdata = head[7:0];
    if (clr_we) begin
      ram_waddr = clr_ptr_q;
      ram_wdata = (clr_ptr_q < ATTR_BASE) ? 8'h00 : clr_attr_q;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (vid_req)     ram_rdata_q     <= mem[vid_addr];
    else if (ram_we) mem[ram_waddr]  <= ram_wdata;
  end

  // Second stage: vid_data is valid two cycles after vid_req and holds
  // until the next read completes.
  always_ff @(posedge clk_pix or negedge nreset) begin
    if (!nreset) begin
      rd_pend_q  <= 1'b0;
      vid_data_q <= '0;
    end else begin
      rd_pend_q <= vid_req;
      if (rd_pend_q) vid_data_q <= ram_rdata_q;
    end
  end

  assign vid_data = vid_data_q;

endmodule

// File: doc/ula_vram_port.md
Name: ula_vram_port

Overview:
- Responder side of the ULA video RAM fetch interface.
- Owns the 8 KB screen RAM and answers the 13-bit address / 8-bit data reads issued by the HDMI video generator.
- Accepts Z80 screen writes through a small write FIFO and drains them only in cycles the video fetch leaves free.
- Provides a hardware clear-screen sweep for fast CLS.

Parameters:
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two, 2..16).
- SCREEN_BYTES, 6912, bytes covered by the clear sweep (bitmap 6144 + attributes 768).
- ATTR_BASE, 13'h1800, first attribute byte in VRAM space.

Ports:
- clk_pix  in  1  pixel clock (25.2 MHz).
- nreset  in  1  asynchronous active-low reset.
- vid_req  in  1  video read strobe; vid_addr valid this cycle.
- vid_addr  in  13  video read address.
- vid_data  out  8  video read data.
- cpu_wr_req  in  1  CPU write request.
- cpu_addr  in  16  Z80 address.
- cpu_wdata  in  8  write data.
- cpu_wr_ready  out  1  FIFO can accept a request.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- clr_start  in  1  clear-screen request pulse.
- clr_attr  in  8  attribute fill value, sampled on accepted clr_start.
- clr_busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async assert, sync release):
  - vid_data=0, FIFO empty, fifo_level=0, cpu_wr_ready=1, clr_busy=0, FSM=IDLE.
  - RAM contents are not cleared.
- RAM: single-port, 8192x8, one access per cycle, synchronous read with 1-cycle latency.
- Video read path:
  - Video has absolute priority.
  - vid_req=1 in cycle N drives vid_addr to RAM in cycle N.
  - vid_data updates at the rising edge ending cycle N+1, so it is valid in cycle N+2.
  - vid_data holds until the next read completes.
  - Back-to-back vid_req on every cycle is supported at full rate.
- CPU write acceptance:
  - A write is accepted when cpu_wr_req=1 and cpu_wr_ready=1.
  - In range (0x4000 <= cpu_addr <= 0x5AFF): push {cpu_addr-0x4000, cpu_wdata}.
  - Out of range: consumed and discarded, no push, fifo_level unchanged.
  - cpu_wr_ready = !full, where full means fifo_level==FIFO_DEPTH.
  - Push while full cannot occur.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO drain:
  - In any cycle with vid_req=0, FSM=IDLE and FIFO non-empty, the head entry is written to RAM and popped.
  - Exactly one pop per free cycle.
  - A write accepted in cycle N can commit at the earliest in cycle N+1.
  - No bypass: a video read of an address with a pending FIFO entry returns the old RAM byte.
  - A read issued in the cycle after the commit returns the new byte.
- Clear FSM states:
  - IDLE to CLEAR on clr_start=1: latch clr_attr, set clr_ptr=0, set clr_busy=1 from the next cycle.
  - CLEAR: in each cycle with vid_req=0, write RAM[clr_ptr] and increment clr_ptr.
    - Value is 8'h00 if clr_ptr < ATTR_BASE, otherwise the latched attribute.
  - CLEAR to IDLE after the write at clr_ptr==SCREEN_BYTES-1; clr_busy drops the following cycle.
- Clear interaction rules:
  - clr_start while busy is ignored.
  - FIFO drain is paused during CLEAR; CPU writes are still accepted into the FIFO until it is full.
  - Entries pending at clr_start drain after the sweep and overwrite the cleared bytes.
  - Reset during CLEAR aborts the sweep immediately, leaving RAM partially cleared.
- Video starvation: a continuously asserted vid_req stalls both the drain and the clear indefinitely, with no data loss.
  - Minimum sweep time is SCREEN_BYTES cycles.
- Arithmetic:
  - cpu_addr-0x4000 is truncated to 13 bits.
  - clr_ptr is 13 bits and never exceeds SCREEN_BYTES-1.
  - Addresses 0x1B00..0x1FFF are never touched by the clear sweep.

Test Plan:
1. Reset, preload RAM[0x0123]=0xA5, pulse vid_req with vid_addr=0x0123 in cycle 10 -> vid_data=0xA5 from cycle 12; vid_data=0 before the first read.
2. CPU writes 0x4000<=0x3C and 0x5800<=0x47 with vid_req=0 -> fifo_level rises to at most 1; video reads of 0x0000 and 0x1800 return 0x3C and 0x47.
3. Write to 0x3FFF and 0x5B00 -> accepted (ready=1), fifo_level stays 0, VRAM unchanged.
4. Hold vid_req=1, issue 5 writes -> first 4 push, cpu_wr_ready=0 after the 4th, 5th held; release vid_req -> 4 commits in 4 cycles, 5th accepted, level returns to 0.
5. clr_start with clr_attr=0x38, vid_req toggling 50% -> clr_busy high about 13824 cycles; RAM[0x0000..0x17FF]=0x00, RAM[0x1800..0x1AFF]=0x38, RAM[0x1B00] unchanged; second clr_start mid-sweep ignored.
6. Assert nreset low mid-clear at clr_ptr=100 -> clr_busy=0 asynchronously, RAM[99]=0, RAM[100] unchanged, FIFO empty.
